ts_packet_buffer: RTL and testbench
===================================

// Module: ts_packet_buffer
// PURPOSE
//  Per-tuner TS packet store in front of source_switch; one instance per source (4 total).
//  - Write side: captures 188-byte TS packets from the tuner byte stream, already sampled into SYS_CLK.
//  - Read side: flags GOT_FULL_PACKET while a complete packet is stored.
//  - On one GIVE_ME_ONE_PACKET pulse, replays that packet byte-per-clock at the exact latency source_switch expects.
// PARAMETERS
//  PKT_SLOTS   4      packet slots; power of two, 2..16; RAM = PKT_SLOTS*256 x 8 (slot*256 + offset addressing)
//  PKT_LEN     188    bytes per TS packet; must be <= 256
//  RD_LATENCY  3      edges from GIVE sample to first byte sample by consumer (fixed by source_switch)
// PORTS
//  SYS_CLK             in   1  single clock; all logic rising-edge
//  RST                 in   1  asynchronous reset, active-high
//  BYTE_EN             in   1  one-cycle strobe: DATA_IN/D_VALID_IN/P_SYNC_IN carry a new tuner byte
//  DATA_IN             in   8  tuner TS byte
//  D_VALID_IN          in   1  byte valid (qualifies BYTE_EN)
//  P_SYNC_IN           in   1  marks first byte of a packet (0x47)
//  GIVE_ME_ONE_PACKET  in   1  one-cycle read request from source_switch
//  DATA_OUT            out  8  packet byte to source_switch (DATA_IN_n)
//  GOT_FULL_PACKET     out  1  >=1 complete, unrequested packet stored
//  SYNC_ERR            out  1  one-cycle pulse: packet discarded (bad sync byte or early P_SYNC)
//  DROP_CNT            out  8  saturating count of packets dropped for lack of a free slot
// BEHAVIOUR
//  Reset: DATA_OUT=0, GOT_FULL_PACKET=0, SYNC_ERR=0, DROP_CNT=0; pointers, counters, FSMs idle. Reset mid-packet discards everything; RAM contents don't care.
//  Write accept: byte taken only when BYTE_EN & D_VALID_IN.
//  Write FSM:
//   W_HUNT: accepted byte with P_SYNC_IN=1 starts a packet.
//    - If DATA_IN != 8'h47: pulse SYNC_ERR, stay.
//    - Else if used_slots == PKT_SLOTS: DROP_CNT++ (sat at 255), go W_SKIP.
//    - Else write offset 0 to slot wr_slot, used_slots++, go W_FILL.
//   W_FILL: each accepted byte written at offset+1; D_VALID_IN low pauses, nothing lost.
//    - On PKT_LEN-th byte: full_pkts++, wr_slot++ (wraps mod PKT_SLOTS), go W_HUNT.
//    - P_SYNC_IN before PKT_LEN bytes: abandon slot (used_slots--), pulse SYNC_ERR, reprocess this byte as in W_HUNT (same cycle).
//   W_SKIP: discard bytes until next accepted P_SYNC_IN byte, handled as W_HUNT.
//  GOT_FULL_PACKET = registered (full_pkts != 0); updated the edge after the counter changes.
//  GIVE handling (only in R_IDLE):
//   - GIVE sampled high with full_pkts > 0: full_pkts-- on that edge (e0), go R_PLAY on rd_slot.
//   - GIVE with full_pkts == 0, or while in R_PLAY: ignored, no state change.
//  Read timing (e0 = edge GIVE sampled):
//   - RAM addr offset 0 at e1; DATA_OUT = byte 0 from e2; byte k on DATA_OUT over the cycle ending at edge e3+k.
//   - Last byte (187) held through e190; at e190 DATA_OUT <= 0.
//   - At e190: used_slots--, rd_slot++ (wraps), back to R_IDLE.
//   - DATA_OUT = 0 whenever not in R_PLAY.
//  Slot in R_PLAY is never reused by write before release.
//  Simultaneous full_pkts ++/-- on one edge: net 0. Same for used_slots alloc/release.
//  Read FSM independent of write FSM. Write may fill other slots during playback.
//  Counter widths: full_pkts/used_slots log2(PKT_SLOTS)+1 bits; no over/underflow reachable.
// TESTING
//  1 One 188-byte packet (0x47,1..187), BYTE_EN every 4th clk -> GOT_FULL_PACKET=1 one edge after byte 188 written; GIVE pulse -> DATA_OUT 0x47 at e3, byte k at e3+k, 0 from e191, GOT_FULL=0 from e1.
//  2 Write 5 packets back-to-back, no reads, PKT_SLOTS=4 -> 4 stored, DROP_CNT=1, 5th packet's bytes never appear; then 4 GIVEs replay packets 1-4 in order.
//  3 P_SYNC_IN at byte 100 of packet A, then full packet B -> SYNC_ERR one pulse; only B read back; used_slots returns to 0 after read.
//  4 First byte 0x46 with P_SYNC_IN -> SYNC_ERR pulse, nothing stored, GOT_FULL stays 0; GIVE then -> DATA_OUT stays 0.
//  5 Packet completes on same edge GIVE is sampled with full_pkts=1 -> full_pkts stays 1, GOT_FULL stays 1; playback correct.
//  6 RST asserted mid-write and mid-playback -> all outputs 0 immediately; next clean packet stored and replayed correctly.

Source files
------------

// File: rtl/ts_packet_buffer.sv
// ts_packet_buffer: per-tuner TS packet store. Captures whole packets into
// slot-addressed RAM and replays one packet per GIVE_ME_ONE_PACKET request.
module ts_packet_buffer #(
    parameter int unsigned PKT_SLOTS  = 4,
    parameter int unsigned PKT_LEN    = 188,
    parameter int unsigned RD_LATENCY = 3
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       BYTE_EN,
    input  logic [7:0] DATA_IN,
    input  logic       D_VALID_IN,
    input  logic       P_SYNC_IN,
    input  logic       GIVE_ME_ONE_PACKET,
    output logic [7:0] DATA_OUT,
    output logic       GOT_FULL_PACKET,
    output logic       SYNC_ERR,
    output logic [7:0] DROP_CNT
);

    localparam int unsigned SLOT_W = $clog2(PKT_SLOTS);
    localparam int unsigned CNT_W  = SLOT_W + 1;
    localparam int unsigned ADDR_W = SLOT_W + 8;

    localparam logic [7:0]       SYNC_BYTE  = 8'h47;
    localparam logic [7:0]       LAST_OFF   = 8'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] SLOTS_FULL = CNT_W'(PKT_SLOTS);
    localparam logic [9:0]       LEAD       = 10'(RD_LATENCY - 3);
    localparam logic [9:0]       LAST_RD    = LEAD + 10'(PKT_LEN);
    localparam logic [9:0]       DONE_CNT   = LAST_RD + 10'd1;

    typedef enum logic [1:0] {
        W_HUNT,
        W_FILL,
        W_SKIP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_PLAY
    } rd_state_t;

    logic [7:0] mem [PKT_SLOTS*256];

    wr_state_t         w_state;
    rd_state_t         r_state;
    logic [SLOT_W-1:0] wr_slot;
    logic [SLOT_W-1:0] rd_slot;
    logic [7:0]        wr_off;
    logic [CNT_W-1:0]  used_slots;
    logic [CNT_W-1:0]  full_pkts;
    logic [9:0]        play_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        rd_off;

    logic accept;
    logic restart;
    logic bad_sync;
    logic w_abandon;
    logic w_drop;
    logic w_alloc;
    logic w_fill;
    logic w_complete;
    logic we;
    logic r_take;
    logic r_release;

    // An accepted sync byte is a packet start in every write state; an
    // abandoned slot frees one entry, so the restart always finds room.
    always_comb begin
        accept     = BYTE_EN & D_VALID_IN;
        restart    = accept & P_SYNC_IN;
        w_abandon  = restart & (w_state == W_FILL);
        bad_sync   = restart & (DATA_IN != SYNC_BYTE);
        w_drop     = restart & ~bad_sync & ~w_abandon & (used_slots == SLOTS_FULL);
        w_alloc    = restart & ~bad_sync & ~w_drop;
        w_fill     = accept & ~P_SYNC_IN & (w_state == W_FILL);
        w_complete = w_fill & (wr_off == LAST_OFF);
        we         = w_alloc | w_fill;
        wr_addr    = {wr_slot, (w_alloc ? 8'd0 : wr_off)};
        r_take     = (r_state == R_IDLE) & GIVE_ME_ONE_PACKET & (full_pkts != '0);
        r_release  = (r_state == R_PLAY) & (play_cnt == DONE_CNT);
        rd_off     = play_cnt[7:0] - LEAD[7:0];
    end

    always_ff @(posedge SYS_CLK) begin
        if (we) begin
            mem[wr_addr] <= DATA_IN;
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            w_state  <= W_HUNT;
            wr_slot  <= '0;
            wr_off   <= '0;
            SYNC_ERR <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            SYNC_ERR <= bad_sync | w_abandon;
            if (w_drop && DROP_CNT != 8'hFF) begin
                DROP_CNT <= DROP_CNT + 8'd1;
            end
            if (restart) begin
                if (bad_sync) begin
                    w_state <= W_HUNT;
                end else if (w_drop) begin
                    w_state <= W_SKIP;
                end else begin
                    w_state <= W_FILL;
                    wr_off  <= 8'd1;
                end
            end else if (w_fill) begin
                wr_off <= wr_off + 8'd1;
                if (w_complete) begin
                    w_state <= W_HUNT;
                    wr_slot <= wr_slot + SLOT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            full_pkts       <= '0;
            used_slots      <= '0;
            GOT_FULL_PACKET <= 1'b0;
        end else begin
            GOT_FULL_PACKET <= (full_pkts != '0);
            full_pkts       <= full_pkts + CNT_W'(w_complete) - CNT_W'(r_take);
            used_slots      <= used_slots + CNT_W'(w_alloc) - CNT_W'(w_abandon)
                               - CNT_W'(r_release);
        end
    end

    // Address issued one edge ahead of the registered RAM read, so byte k
    // lands on DATA_OUT at edge e(RD_LATENCY-1+k).
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_state  <= R_IDLE;
            rd_slot  <= '0;
            play_cnt <= '0;
            rd_addr  <= '0;
            DATA_OUT <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (r_take) begin
                        r_state  <= R_PLAY;
                        play_cnt <= '0;
                    end
                end
                R_PLAY: begin
                    play_cnt <= play_cnt + 10'd1;
                    rd_addr  <= {rd_slot, rd_off};
                    if (play_cnt > LEAD && play_cnt <= LAST_RD) begin
                        DATA_OUT <= mem[rd_addr];
                    end
                    if (r_release) begin
                        r_state  <= R_IDLE;
                        rd_slot  <= rd_slot + SLOT_W'(1);
                        DATA_OUT <= '0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_packet_buffer.sv
// tb_ts_packet_buffer: directed scenarios plus randomized traffic, checked
// cycle by cycle against a packet-level reference model.
module tb_ts_packet_buffer;

    localparam int unsigned PKT_SLOTS = 4;
    localparam int unsigned PKT_LEN   = 188;

    logic       SYS_CLK = 1'b0;
    logic       RST;
    logic       BYTE_EN;
    logic [7:0] DATA_IN;
    logic       D_VALID_IN;
    logic       P_SYNC_IN;
    logic       GIVE_ME_ONE_PACKET;
    logic [7:0] DATA_OUT;
    logic       GOT_FULL_PACKET;
    logic       SYNC_ERR;
    logic [7:0] DROP_CNT;

    always #5 SYS_CLK = ~SYS_CLK;

    ts_packet_buffer #(
        .PKT_SLOTS (PKT_SLOTS),
        .PKT_LEN   (PKT_LEN),
        .RD_LATENCY(3)
    ) dut (
        .SYS_CLK           (SYS_CLK),
        .RST               (RST),
        .BYTE_EN           (BYTE_EN),
        .DATA_IN           (DATA_IN),
        .D_VALID_IN        (D_VALID_IN),
        .P_SYNC_IN         (P_SYNC_IN),
        .GIVE_ME_ONE_PACKET(GIVE_ME_ONE_PACKET),
        .DATA_OUT          (DATA_OUT),
        .GOT_FULL_PACKET   (GOT_FULL_PACKET),
        .SYNC_ERR          (SYNC_ERR),
        .DROP_CNT          (DROP_CNT)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: stored packets as a FIFO of bytes, one packet in
    // collection, one packet in playback.
    logic [7:0]  stored[$];
    logic [7:0]  cur[$];
    bit          collecting;
    int unsigned m_full;
    int unsigned m_drop;
    bit          playing;
    int unsigned play_n;
    logic [7:0]  play_pkt [PKT_LEN];
    logic [7:0]  exp_data;
    logic        exp_got;
    logic        exp_err;
    int unsigned give_pm;

    task automatic model_step();
        int unsigned pre_full;
        int unsigned used;
        if (RST) begin
            stored.delete();
            cur.delete();
            collecting = 0;
            m_full     = 0;
            m_drop     = 0;
            playing    = 0;
            play_n     = 0;
            exp_data   = '0;
            exp_got    = 1'b0;
            exp_err    = 1'b0;
            return;
        end
        pre_full = m_full;
        used     = m_full + (collecting ? 1 : 0) + (playing ? 1 : 0);
        exp_got  = (pre_full != 0);
        exp_err  = 1'b0;
        exp_data = '0;
        if (playing) begin
            play_n++;
            if (play_n >= 2 && play_n <= PKT_LEN + 1) exp_data = play_pkt[play_n - 2];
            if (play_n == PKT_LEN + 2) playing = 0;
        end else if (GIVE_ME_ONE_PACKET && pre_full != 0) begin
            for (int unsigned k = 0; k < PKT_LEN; k++) play_pkt[k] = stored.pop_front();
            m_full--;
            playing = 1;
            play_n  = 0;
        end
        if (BYTE_EN && D_VALID_IN) begin
            if (P_SYNC_IN) begin
                if (collecting) begin
                    collecting = 0;
                    cur.delete();
                    exp_err = 1'b1;
                    used--;
                end
                if (DATA_IN != 8'h47) begin
                    exp_err = 1'b1;
                end else if (used == PKT_SLOTS) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    collecting = 1;
                    cur.push_back(DATA_IN);
                end
            end else if (collecting) begin
                cur.push_back(DATA_IN);
                if (cur.size() == PKT_LEN) begin
                    foreach (cur[i]) stored.push_back(cur[i]);
                    cur.delete();
                    collecting = 0;
                    m_full++;
                end
            end
        end
    endtask

    task automatic noise();
        GIVE_ME_ONE_PACKET = 1'b0;
        if ($urandom_range(1) == 0) begin
            BYTE_EN    = 1'b0;
            D_VALID_IN = 1'($urandom_range(1));
        end else begin
            BYTE_EN    = 1'b1;
            D_VALID_IN = 1'b0;
        end
        DATA_IN   = 8'($urandom);
        P_SYNC_IN = 1'($urandom_range(1));
    endtask

    task automatic tick();
        if (give_pm != 0 && $urandom_range(999) < give_pm) GIVE_ME_ONE_PACKET = 1'b1;
        model_step();
        @(posedge SYS_CLK);
        #1;
        check_val("DATA_OUT", DATA_OUT, exp_data);
        check_val("GOT_FULL_PACKET", 8'(GOT_FULL_PACKET), 8'(exp_got));
        check_val("SYNC_ERR", 8'(SYNC_ERR), 8'(exp_err));
        check_val("DROP_CNT", DROP_CNT, 8'(m_drop));
        noise();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input int unsigned gap,
                             input bit give);
        repeat (gap) tick();
        BYTE_EN    = 1'b1;
        D_VALID_IN = 1'b1;
        DATA_IN    = d;
        P_SYNC_IN  = s;
        if (give) GIVE_ME_ONE_PACKET = 1'b1;
        tick();
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each byte
    task automatic send_pkt(input logic [7:0] first, input int unsigned len, input bit seq,
                            input int gap, input bit give_last);
        for (int unsigned i = 0; i < len; i++) begin
            logic [7:0]  d;
            int unsigned g;
            d = (i == 0) ? first : (seq ? 8'(i) : 8'($urandom));
            g = (gap < 0) ? $urandom_range(3) : unsigned'(gap);
            send_byte(d, (i == 0), g, give_last && (i == len - 1));
        end
    endtask

    task automatic drain();
        int unsigned budget = 5000;
        while ((m_full != 0 || playing) && budget != 0) begin
            if (!playing && m_full != 0) GIVE_ME_ONE_PACKET = 1'b1;
            tick();
            budget--;
        end
        check_val("drain_done", 8'((m_full != 0 || playing) ? 1 : 0), 8'd0);
    endtask

    task automatic do_reset();
        #2 RST = 1'b1;
        #1;
        check_val("rst_DATA_OUT", DATA_OUT, 8'd0);
        check_val("rst_GOT_FULL", 8'(GOT_FULL_PACKET), 8'd0);
        check_val("rst_SYNC_ERR", 8'(SYNC_ERR), 8'd0);
        check_val("rst_DROP_CNT", DROP_CNT, 8'd0);
        tick();
        tick();
        #2 RST = 1'b0;
    endtask

    task automatic random_pkt();
        int unsigned k = $urandom_range(9);
        if (k == 0)
            send_pkt(8'h47 ^ 8'($urandom_range(255, 1)), 12, 0, -1, 0);
        else if (k == 1)
            send_pkt(8'h47, $urandom_range(PKT_LEN - 1, 1), 0, -1, 0);
        else
            send_pkt(8'h47, PKT_LEN, 0, -1, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST     = 1'b1;
        give_pm = 0;
        noise();
        repeat (3) tick();
        #2 RST = 1'b0;

        // single packet, byte every 4th clock, then one read
        send_pkt(8'h47, PKT_LEN, 1, 3, 0);
        repeat (5) tick();
        GIVE_ME_ONE_PACKET = 1'b1;
        tick();
        repeat (195) tick();

        // overflow: five packets, four slots
        repeat (5) send_pkt(8'h47, PKT_LEN, 0, -1, 0);
        repeat (3) tick();
        drain();

        // early sync abandons packet A
        send_pkt(8'h47, 100, 0, -1, 0);
        send_pkt(8'h47, PKT_LEN, 0, -1, 0);
        drain();

        // bad sync byte, then a request with nothing stored
        send_pkt(8'h46, 20, 0, -1, 0);
        GIVE_ME_ONE_PACKET = 1'b1;
        tick();
        repeat (10) tick();

        // completion and request on the same edge
        send_pkt(8'h47, PKT_LEN, 0, -1, 0);
        send_pkt(8'h47, PKT_LEN, 0, -1, 1);
        drain();

        // reset mid-write and mid-playback
        send_pkt(8'h47, 100, 0, -1, 0);
        do_reset();
        send_pkt(8'h47, PKT_LEN, 0, -1, 0);
        GIVE_ME_ONE_PACKET = 1'b1;
        tick();
        repeat (50) tick();
        do_reset();
        send_pkt(8'h47, PKT_LEN, 0, -1, 0);
        drain();

        // random traffic: slow reader then fast reader
        give_pm = 1;
        repeat (20) random_pkt();
        give_pm = 30;
        repeat (20) random_pkt();
        give_pm = 0;
        drain();
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
